tl45_scoreboard: RTL and testbench
==================================

Name: tl45_scoreboard

Overview:
- Hazard controller for the register-read stage of the tl45 pipeline.
- Keeps a per-register pending-write scoreboard for long-latency ops (loads) whose results cannot be supplied by the operand forwarding buses.
- Generates the pipeline stall when a source or destination register is pending.
- Sequences multi-cycle flushes on taken branches and provides stall performance and deadlock monitoring.

Parameters:
- NREGS, 16, number of architectural registers; r0 is hardwired zero.
- FLUSH_CYCLES, 2, number of cycles o_pipe_flush is held per taken branch (>=1).
- STALL_LIMIT, 64, consecutive hazard-stall cycles before o_deadlock is set.
- CNT_W, 32, width of the stall performance counter.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_issue_valid  in  1  decode presents an instruction to register read.
- i_issue_sr1  in  4  source register 1.
- i_issue_sr2  in  4  source register 2.
- i_issue_uses_sr2  in  1  0 in immediate mode (sr2 ignored).
- i_issue_dr  in  4  destination register.
- i_issue_long  in  1  op completes at writeback only (load); result is not forwardable.
- i_wb_valid  in  1  long-op writeback completes this cycle.
- i_wb_reg  in  4  register written back.
- i_ext_stall  in  1  stall from downstream (memory).
- i_branch_taken  in  1  branch resolved taken this cycle.
- o_pipe_stall  out  1  stall to register-read stage.
- o_pipe_flush  out  1  flush to register-read stage.
- o_pending  out  NREGS  scoreboard bitmap; bit0 always 0.
- o_stall_count  out  CNT_W  total stalled cycles, saturating.
- o_deadlock  out  1  sticky hazard-stall timeout flag.

Behaviour:
- Reset (sync, i_reset=1 at posedge):
  - o_pending=0, flush counter=0, stall-run counter=0, o_stall_count=0, o_deadlock=0.
  - Combinational outputs during reset follow from the cleared state.
- Writeback clear mask: wb_clr = i_wb_valid && i_wb_reg!=0 ? onehot(i_wb_reg) : 0.
- Effective pending: eff = o_pending & ~wb_clr. Writeback bypasses into the same-cycle hazard check.
- Hazard, combinational:
  - i_issue_valid && (eff[sr1] || (i_issue_uses_sr2 && eff[sr2]) || eff[dr]).
  - The dr check is the WAW check.
  - Index 0 never hazards.
- Flush, combinational: o_pipe_flush = i_branch_taken || flush_cnt!=0.
- Flush counter:
  - On i_branch_taken, flush_cnt <= FLUSH_CYCLES-1 (reload even if already counting).
  - Otherwise decrement while nonzero.
  - Flush lasts exactly FLUSH_CYCLES cycles from the branch cycle.
- Stall, combinational: o_pipe_stall = !o_pipe_flush && (hazard || i_ext_stall). Flush has priority over stall.
- Accept: accept = i_issue_valid && !o_pipe_stall && !o_pipe_flush.
- Scoreboard update each cycle:
  - o_pending <= eff | set_mask.
  - set_mask = accept && i_issue_long && dr!=0 ? onehot(dr) : 0.
  - Set wins over a same-cycle clear of the same register.
- Flush does not clear pending bits; in-flight long ops are older than the branch and still write back.
- Writeback to a non-pending register is a no-op. Writeback to r0 is ignored.
- Stall counter: o_stall_count increments on every cycle o_pipe_stall=1; saturates at all-ones.
- Deadlock monitor:
  - stall-run counter increments on cycles with hazard && !o_pipe_flush (excluding pure ext stall).
  - Counter is cleared on any other cycle.
  - When it reaches STALL_LIMIT, o_deadlock <= 1 and stays set until reset. The counter saturates.
- Reset mid-flush or mid-stall: all state clears next edge. No pending write is remembered.

Test Plan:
- Reset, then issue load dr=3 accepted:
  - o_pending=0x0008 next cycle.
  - Next issue sr1=3 -> o_pipe_stall=1.
  - i_wb_valid, i_wb_reg=3 -> same cycle o_pipe_stall=0, issue accepted, o_pending=0x0000.
- Pending r5; issue ri-mode (uses_sr2=0) sr2=5, sr1=1, dr=2 -> no stall. Same with uses_sr2=1 -> stall.
- i_branch_taken one cycle with FLUSH_CYCLES=2:
  - o_pipe_flush=1 for exactly 2 cycles; o_pipe_stall=0 during them.
  - Load issued during flush does not set pending.
  - Second branch in cycle 2 extends flush to 3 total cycles.
- Pending r4, issue load dr=4 while wb r4 same cycle -> accepted, o_pending bit4 remains 1.
- Hold hazard on r7 with no writeback:
  - o_deadlock rises after 64 stall cycles; o_stall_count=64.
  - o_deadlock stays 1 after wb; cleared only by i_reset.
- i_ext_stall=1 for 10 cycles with no hazard:
  - o_pipe_stall=1, o_stall_count +=10, o_deadlock stays 0.
  - Issue r0 sources/dest never stall; wb to r0 leaves o_pending unchanged.

Source files
------------

// File: rtl/tl45_scoreboard_if.sv
// Register-read hazard interface for tl45: issue/writeback/branch inputs and
// stall/flush/monitor outputs of the scoreboard.
interface tl45_scoreboard_if #(
  parameter int unsigned NREGS = 16,
  parameter int unsigned CNT_W = 32
);
  localparam int unsigned RW = $clog2(NREGS);

  logic             i_issue_valid;
  logic [RW-1:0]    i_issue_sr1;
  logic [RW-1:0]    i_issue_sr2;
  logic             i_issue_uses_sr2;
  logic [RW-1:0]    i_issue_dr;
  logic             i_issue_long;
  logic             i_wb_valid;
  logic [RW-1:0]    i_wb_reg;
  logic             i_ext_stall;
  logic             i_branch_taken;
  logic             o_pipe_stall;
  logic             o_pipe_flush;
  logic [NREGS-1:0] o_pending;
  logic [CNT_W-1:0] o_stall_count;
  logic             o_deadlock;

  modport slave (
    input  i_issue_valid, i_issue_sr1, i_issue_sr2, i_issue_uses_sr2,
           i_issue_dr, i_issue_long, i_wb_valid, i_wb_reg, i_ext_stall,
           i_branch_taken,
    output o_pipe_stall, o_pipe_flush, o_pending, o_stall_count, o_deadlock
  );

  modport master (
    output i_issue_valid, i_issue_sr1, i_issue_sr2, i_issue_uses_sr2,
           i_issue_dr, i_issue_long, i_wb_valid, i_wb_reg, i_ext_stall,
           i_branch_taken,
    input  o_pipe_stall, o_pipe_flush, o_pending, o_stall_count, o_deadlock
  );
endinterface

// File: rtl/tl45_scoreboard.sv
// tl45 register-read hazard controller: pending-write scoreboard for loads,
// stall/flush generation, stall counter and hazard deadlock monitor.
module tl45_scoreboard #(
  parameter int unsigned NREGS        = 16,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned STALL_LIMIT  = 64,
  parameter int unsigned CNT_W        = 32
) (
  input logic             i_clk,
  input logic             i_reset,
  tl45_scoreboard_if.slave sb
);
  localparam int unsigned FW    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned RUN_W = $clog2(STALL_LIMIT + 1);
  localparam logic [FW-1:0]    FLUSH_RELOAD = FW'(FLUSH_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUN_MAX      = RUN_W'(STALL_LIMIT);
  localparam logic [RUN_W-1:0] RUN_PRE      = RUN_W'(STALL_LIMIT - 1);

  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] wb_clr;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] eff;
  logic [FW-1:0]    flush_cnt;
  logic [RUN_W-1:0] stall_run;
  logic [CNT_W-1:0] stall_count;
  logic             deadlock;
  logic             hazard;
  logic             flush;
  logic             stall;
  logic             accept;

  always_comb begin
    wb_clr = '0;
    if (sb.i_wb_valid && sb.i_wb_reg != '0)
      wb_clr[sb.i_wb_reg] = 1'b1;
  end

  // Writeback bypasses into this cycle's check; bit 0 is never set, so r0 never hazards.
  assign eff = pending & ~wb_clr;

  always_comb begin
    hazard = sb.i_issue_valid &&
             (eff[sb.i_issue_sr1] ||
              (sb.i_issue_uses_sr2 && eff[sb.i_issue_sr2]) ||
              eff[sb.i_issue_dr]);
  end

  assign flush  = sb.i_branch_taken || (flush_cnt != '0);
  assign stall  = !flush && (hazard || sb.i_ext_stall);
  assign accept = sb.i_issue_valid && !stall && !flush;

  always_comb begin
    set_mask = '0;
    if (accept && sb.i_issue_long && sb.i_issue_dr != '0)
      set_mask[sb.i_issue_dr] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pending     <= '0;
      flush_cnt   <= '0;
      stall_run   <= '0;
      stall_count <= '0;
      deadlock    <= 1'b0;
    end else begin
      pending <= eff | set_mask;

      if (sb.i_branch_taken)
        flush_cnt <= FLUSH_RELOAD;
      else if (flush_cnt != '0)
        flush_cnt <= flush_cnt - 1'b1;

      if (stall && stall_count != '1)
        stall_count <= stall_count + 1'b1;

      // Only register hazards count toward deadlock; external stalls reset the run.
      if (hazard && !flush) begin
        if (stall_run != RUN_MAX)
          stall_run <= stall_run + 1'b1;
        if (stall_run >= RUN_PRE)
          deadlock <= 1'b1;
      end else begin
        stall_run <= '0;
      end
    end
  end

  assign sb.o_pipe_stall  = stall;
  assign sb.o_pipe_flush  = flush;
  assign sb.o_pending     = pending;
  assign sb.o_stall_count = stall_count;
  assign sb.o_deadlock    = deadlock;
endmodule

// File: tb/tb_tl45_scoreboard.sv
// Self-checking bench for tl45_scoreboard: expectations queued per cycle from
// the directed stimulus and compared as the DUT produces each output.
module tb_tl45_scoreboard;
  localparam int unsigned NREGS        = 16;
  localparam int unsigned FLUSH_CYCLES = 2;
  localparam int unsigned STALL_LIMIT  = 64;
  localparam int unsigned CNT_W        = 32;

  typedef enum logic [2:0] {S_STALL, S_FLUSH, S_PEND, S_CNT, S_DL} sel_t;
  typedef struct {
    string       tag;
    sel_t        sel;
    logic [63:0] exp;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_reset;
  always #5 i_clk = ~i_clk;

  tl45_scoreboard_if #(.NREGS(NREGS), .CNT_W(CNT_W)) sb_if ();

  tl45_scoreboard #(
    .NREGS(NREGS), .FLUSH_CYCLES(FLUSH_CYCLES),
    .STALL_LIMIT(STALL_LIMIT), .CNT_W(CNT_W)
  ) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .sb     (sb_if.slave)
  );

  exp_t             q[$];
  int unsigned      n_tests = 0;
  int unsigned      n_fail  = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  logic             exp_dl  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] observe(input sel_t s);
    case (s)
      S_STALL: observe = 64'(sb_if.o_pipe_stall);
      S_FLUSH: observe = 64'(sb_if.o_pipe_flush);
      S_PEND:  observe = 64'(sb_if.o_pending);
      S_CNT:   observe = 64'(sb_if.o_stall_count);
      default: observe = 64'(sb_if.o_deadlock);
    endcase
  endfunction

  task automatic push(input string tag, input sel_t s, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = s;
    e.exp = exp;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    drain();
  endtask

  // One cycle: combinational outputs checked before the edge, state after it.
  task automatic cyc(input string tag, input logic st, input logic fl, input logic [15:0] pend);
    push($sformatf("%s.stall", tag), S_STALL, 64'(st));
    push($sformatf("%s.flush", tag), S_FLUSH, 64'(fl));
    if (st && exp_cnt != '1) exp_cnt++;
    #1;
    drain();
    push($sformatf("%s.pending", tag), S_PEND, 64'(pend));
    push($sformatf("%s.count", tag), S_CNT, 64'(exp_cnt));
    push($sformatf("%s.deadlock", tag), S_DL, 64'(exp_dl));
    tick();
  endtask

  task automatic issue(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                       input logic u, input logic [3:0] d, input logic lg);
    sb_if.i_issue_valid    = v;
    sb_if.i_issue_sr1      = s1;
    sb_if.i_issue_sr2      = s2;
    sb_if.i_issue_uses_sr2 = u;
    sb_if.i_issue_dr       = d;
    sb_if.i_issue_long     = lg;
  endtask

  task automatic wb(input logic v, input logic [3:0] r);
    sb_if.i_wb_valid = v;
    sb_if.i_wb_reg   = r;
  endtask

  task automatic idle();
    issue(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    wb(1'b0, 4'd0);
    sb_if.i_ext_stall    = 1'b0;
    sb_if.i_branch_taken = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1;
    idle();
    tick();
    cyc("rst", 1'b0, 1'b0, 16'h0000);
    i_reset = 1'b0;

    // Load to r3, RAW stall, writeback bypass releases it the same cycle
    issue(1'b1, 4'd1, 4'd2, 1'b1, 4'd3, 1'b1); cyc("ld3", 1'b0, 1'b0, 16'h0008);
    issue(1'b1, 4'd3, 4'd0, 1'b0, 4'd4, 1'b0); cyc("raw3", 1'b1, 1'b0, 16'h0008);
    wb(1'b1, 4'd3);                            cyc("wbbyp", 1'b0, 1'b0, 16'h0000);
    idle();

    // sr2 only matters when used
    issue(1'b1, 4'd0, 4'd0, 1'b0, 4'd5, 1'b1); cyc("ld5", 1'b0, 1'b0, 16'h0020);
    issue(1'b1, 4'd1, 4'd5, 1'b0, 4'd2, 1'b0); cyc("ri", 1'b0, 1'b0, 16'h0020);
    issue(1'b1, 4'd1, 4'd5, 1'b1, 4'd2, 1'b0); cyc("rr", 1'b1, 1'b0, 16'h0020);
    idle(); wb(1'b1, 4'd5);                    cyc("wb5", 1'b0, 1'b0, 16'h0000);

    // Branch flush: loads during flush are dropped
    idle(); sb_if.i_branch_taken = 1'b1;
    issue(1'b1, 4'd0, 4'd0, 1'b0, 4'd6, 1'b1); cyc("fl1", 1'b0, 1'b1, 16'h0000);
    sb_if.i_branch_taken = 1'b0;               cyc("fl2", 1'b0, 1'b1, 16'h0000);
    cyc("fl3", 1'b0, 1'b0, 16'h0040);

    // Hazard masked by flush; second branch extends flush to three cycles
    idle(); issue(1'b1, 4'd6, 4'd0, 1'b0, 4'd1, 1'b0);
    sb_if.i_branch_taken = 1'b1;               cyc("fx1", 1'b0, 1'b1, 16'h0040);
    cyc("fx2", 1'b0, 1'b1, 16'h0040);
    sb_if.i_branch_taken = 1'b0;               cyc("fx3", 1'b0, 1'b1, 16'h0040);
    cyc("fx4", 1'b1, 1'b0, 16'h0040);
    wb(1'b1, 4'd6);                            cyc("wb6", 1'b0, 1'b0, 16'h0000);
    idle();

    // WAW: same-cycle writeback and re-issue keeps the bit set
    issue(1'b1, 4'd0, 4'd0, 1'b0, 4'd4, 1'b1); cyc("ld4", 1'b0, 1'b0, 16'h0010);
    issue(1'b1, 4'd1, 4'd2, 1'b1, 4'd4, 1'b1); wb(1'b1, 4'd4);
    cyc("wawwb", 1'b0, 1'b0, 16'h0010);
    idle(); issue(1'b1, 4'd1, 4'd2, 1'b1, 4'd4, 1'b0);
    cyc("waw", 1'b1, 1'b0, 16'h0010);
    idle(); wb(1'b1, 4'd4);                    cyc("wb4", 1'b0, 1'b0, 16'h0000);

    // External stall counts but does not feed the deadlock monitor
    idle(); sb_if.i_ext_stall = 1'b1;
    issue(1'b1, 4'd1, 4'd2, 1'b1, 4'd2, 1'b0);
    for (int i = 0; i < 10; i++) cyc("ext", 1'b1, 1'b0, 16'h0000);
    idle();
    issue(1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 1'b1); cyc("r0", 1'b0, 1'b0, 16'h0000);

    // Reset in the middle of a flush
    idle(); sb_if.i_branch_taken = 1'b1;       cyc("brr", 1'b0, 1'b1, 16'h0000);
    idle(); i_reset = 1'b1; exp_cnt = '0;      cyc("rstfl", 1'b0, 1'b1, 16'h0000);
    i_reset = 1'b0;                            cyc("postrst", 1'b0, 1'b0, 16'h0000);

    // Writeback to r0 is ignored, then sustained hazard trips deadlock
    issue(1'b1, 4'd0, 4'd0, 1'b0, 4'd7, 1'b1); cyc("ld7", 1'b0, 1'b0, 16'h0080);
    idle(); wb(1'b1, 4'd0);                    cyc("wbr0", 1'b0, 1'b0, 16'h0080);
    idle(); issue(1'b1, 4'd7, 4'd0, 1'b0, 4'd1, 1'b0);
    for (int i = 1; i <= 65; i++) begin
      if (i >= STALL_LIMIT) exp_dl = 1'b1;
      cyc("dl", 1'b1, 1'b0, 16'h0080);
    end
    wb(1'b1, 4'd7);                            cyc("dlwb", 1'b0, 1'b0, 16'h0000);
    idle(); i_reset = 1'b1; exp_cnt = '0; exp_dl = 1'b0;
    cyc("dlrst", 1'b0, 1'b0, 16'h0000);
    i_reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
